// File: rtl/fmap_write_arbiter.sv
// fmap_write_arbiter: round-robin share of one BRAM write port among
// N_REQ feature-map capture channels, with per-channel column addressing.
// Ports: clk, rst_n, frame_start, req_valid/req_data/req_ready (channels),
//   bram_addr_a/bram_wrdata_a/bram_we_a (BRAM port A), ch_done, all_done,
//   overrun; stall_cycles/beats only when FMAP_ARB_STATS_EN is defined.
module fmap_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 192,
  parameter int ADDR_W = 12,
  parameter int COLS = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h000,
  parameter logic [ADDR_W-1:0] CH_STRIDE = 12'h020,
  parameter int HOLD_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       bram_addr_a,
  output logic [DATA_W-1:0]       bram_wrdata_a,
  output logic                    bram_we_a,
  output logic [N_REQ-1:0]        ch_done,
  output logic                    all_done,
  output logic                    overrun
`ifdef FMAP_ARB_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [15:0]             beats
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state, state_nx;

  logic [HLD_W-1:0]  hold_cnt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  col_cnt [N_REQ];
  logic [N_REQ-1:0]  done_mask;
  logic [N_REQ-1:0]  elig;
  logic              found;
  logic              arb_slot;
  logic              grant;
  logic              win_last;
  logic              full_q;
  logic [PTR_W-1:0]  win;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    elig = req_valid & ~done_mask;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    // last hold cycle of a beat doubles as the next arbitration slot
    arb_slot = (state == IDLE) || (hold_cnt == '0);
    grant = arb_slot && found && !frame_start;
    win_data = req_data[int'(win)*DATA_W +: DATA_W];
    win_addr = BASE_ADDR
             + ADDR_W'(win) * CH_STRIDE
             + ADDR_W'(col_cnt[win]);
    win_last = (col_cnt[win] == CNT_W'(COLS - 1));
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (grant) state_nx = WRITE;
      WRITE: if (hold_cnt == '0 && !grant) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bram_we_a = (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      rr_ptr <= '0;
      done_mask <= '0;
      for (int i = 0; i < N_REQ; i++) col_cnt[i] <= '0;
      bram_addr_a <= BASE_ADDR;
      bram_wrdata_a <= '0;
      ch_done <= '0;
      all_done <= 1'b0;
      full_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      ch_done <= '0;
      if (grant) begin
        hold_cnt <= HLD_W'(HOLD_CYC - 1);
        bram_addr_a <= win_addr;
        bram_wrdata_a <= win_data;
        rr_ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        if (win_last) begin
          col_cnt[win] <= '0;
          done_mask[win] <= 1'b1;
          ch_done[win] <= 1'b1;
        end else begin
          col_cnt[win] <= col_cnt[win] + 1'b1;
        end
      end else if (state == WRITE && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (frame_start) begin
        for (int i = 0; i < N_REQ; i++) col_cnt[i] <= '0;
        done_mask <= '0;
        rr_ptr <= '0;
      end
      // rising edge of the full mask gives one pulse per frame
      full_q <= &done_mask;
      all_done <= (&done_mask) && !full_q;
      if (|(req_valid & done_mask) && !frame_start) overrun <= 1'b1;
    end
  end

`ifdef FMAP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      beats <= '0;
    end else if (frame_start) begin
      stall_cycles <= '0;
      beats <= '0;
    end else begin
      if (|elig && !grant && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (grant) beats <= beats + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_write_arbiter.sv
// tb_fmap_write_arbiter: directed table and sequence checks for
// fmap_write_arbiter at default parameters.
module tb_fmap_write_arbiter;

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic [3:0]   req_valid;
  logic [767:0] req_data;
  logic [3:0]   req_ready;
  logic [11:0]  bram_addr_a;
  logic [191:0] bram_wrdata_a;
  logic         bram_we_a;
  logic [3:0]   ch_done;
  logic         all_done;
  logic         overrun;
`ifdef FMAP_ARB_STATS_EN
  logic [31:0]  stall_cycles;
  logic [15:0]  beats;
`endif

  logic [191:0] data [4];
  int           sent [4];
  logic [3:0]   rdy_seen;
  int           checks;
  int           errors;

  assign req_data = {data[3], data[2], data[1], data[0]};

  fmap_write_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .bram_addr_a(bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a),
    .bram_we_a(bram_we_a),
    .ch_done(ch_done),
    .all_done(all_done),
    .overrun(overrun)
`ifdef FMAP_ARB_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .beats(beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] mk(int ch, int n);
    return {160'h0, 16'hC0DE, 8'(ch), 8'(n)};
  endfunction

  task automatic chk(input string nm, input int cyc,
                     input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // one cycle: requester advances its word after an accept, then drives
  task automatic step(input logic [3:0] v, input logic fs);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rdy_seen[i]) sent[i]++;
      data[i] = mk(i, sent[i]);
    end
    req_valid = v;
    frame_start = fs;
    #1;
    rdy_seen = req_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    frame_start = 1'b0;
    rdy_seen = '0;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      data[i] = mk(i, 0);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr", 0, bram_addr_a, 12'h000);
    chk("rst_we", 0, bram_we_a, 1'b0);
    chk("rst_rdy", 0, req_ready, 4'h0);
    chk("rst_done", 0, {ch_done, all_done, overrun}, 6'h0);
    chk("rst_wdata", 0, bram_wrdata_a, 192'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic        we;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl [10];

  logic [3:0]   e_rdy;
  logic [3:0]   e_done;
  logic         e_we;
  logic [11:0]  e_addr;
  logic [191:0] e_data;
  int           b;

  initial begin
    checks = 0;
    errors = 0;

    // round robin with channels 0 and 2, pointer moved to 1 first
    tbl[0] = '{4'b0001, 4'b0001, 1'b0, 12'h000};
    tbl[1] = '{4'b0101, 4'b0000, 1'b1, 12'h000};
    tbl[2] = '{4'b0101, 4'b0100, 1'b1, 12'h000};
    tbl[3] = '{4'b0101, 4'b0000, 1'b1, 12'h040};
    tbl[4] = '{4'b0101, 4'b0001, 1'b1, 12'h040};
    tbl[5] = '{4'b0101, 4'b0000, 1'b1, 12'h001};
    tbl[6] = '{4'b0101, 4'b0100, 1'b1, 12'h001};
    tbl[7] = '{4'b0000, 4'b0000, 1'b1, 12'h041};
    tbl[8] = '{4'b0000, 4'b0000, 1'b1, 12'h041};
    tbl[9] = '{4'b0000, 4'b0000, 1'b0, 12'h041};

    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(tbl[c].vld, 1'b0);
      chk("rr_rdy", c, req_ready, tbl[c].rdy);
      chk("rr_we", c, bram_we_a, tbl[c].we);
      if (tbl[c].we) chk("rr_addr", c, bram_addr_a, tbl[c].addr);
    end

    // single channel 1 streams a whole frame
    do_reset();
    for (int c = 0; c < 51; c++) begin
      step(4'b0010, 1'b0);
      e_rdy = (c <= 46 && c % 2 == 0) ? 4'b0010 : 4'b0000;
      e_we = (c >= 1 && c <= 48);
      e_done = (c == 47) ? 4'b0010 : 4'b0000;
      chk("s1_rdy", c, req_ready, e_rdy);
      chk("s1_we", c, bram_we_a, e_we);
      chk("s1_done", c, ch_done, e_done);
      chk("s1_ovr", c, overrun, c >= 48);
      if (e_we) begin
        b = (c - 1) / 2;
        chk("s1_addr", c, bram_addr_a, 12'h020 + 12'(b));
        chk("s1_data", c, bram_wrdata_a, mk(1, b));
      end
    end

    // all four channels, full layer of 96 beats
    do_reset();
    for (int c = 0; c < 197; c++) begin
      step(4'b1111, 1'b0);
      e_rdy = (c <= 190 && c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'h0;
      e_we = (c >= 1 && c <= 192);
      b = (c - 1) / 2;
      e_done = (c % 2 == 1 && c <= 191 && b >= 92) ? 4'(1 << (b % 4)) : 4'h0;
      chk("s4_rdy", c, req_ready, e_rdy);
      chk("s4_we", c, bram_we_a, e_we);
      chk("s4_done", c, ch_done, e_done);
      chk("s4_all", c, all_done, c == 192);
      if (e_we) begin
        e_addr = 12'((b % 4) * 32 + b / 4);
        e_data = mk(b % 4, b / 4);
        chk("s4_addr", c, bram_addr_a, e_addr);
        chk("s4_data", c, bram_wrdata_a, e_data);
      end
    end
    chk("s4_last_addr", 0, bram_addr_a, 12'h077);

    // frame_start in the second hold cycle of a channel-3 beat
    do_reset();
    step(4'b1000, 1'b0);
    chk("fs_rdy0", 0, req_ready, 4'b1000);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("fs_rdy2", 2, req_ready, 4'b1000);
    step(4'b1000, 1'b0);
    chk("fs_addr3", 3, bram_addr_a, 12'h061);
    step(4'b1000, 1'b1);
    chk("fs_rdy4", 4, req_ready, 4'b0000);
    chk("fs_we4", 4, bram_we_a, 1'b1);
    chk("fs_addr4", 4, bram_addr_a, 12'h061);
    step(4'b1000, 1'b0);
    chk("fs_we5", 5, bram_we_a, 1'b0);
    chk("fs_rdy5", 5, req_ready, 4'b1000);
    step(4'b0000, 1'b0);
    chk("fs_we6", 6, bram_we_a, 1'b1);
    chk("fs_addr6", 6, bram_addr_a, 12'h060);

    // asynchronous reset in the middle of a write
    do_reset();
    step(4'b0001, 1'b0);
    chk("ar_rdy0", 0, req_ready, 4'b0001);
    step(4'b0001, 1'b0);
    chk("ar_we1", 1, bram_we_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_we_drop", 1, bram_we_a, 1'b0);
    chk("ar_addr", 1, bram_addr_a, 12'h000);
    req_valid = '0;
    rdy_seen = '0;
    for (int i = 0; i < 4; i++) sent[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 1'b0);
    chk("ar_rdy", 0, req_ready, 4'b0001);
    step(4'b0000, 1'b0);
    chk("ar_we", 1, bram_we_a, 1'b1);
    chk("ar_addr1", 1, bram_addr_a, 12'h000);
    chk("ar_data1", 1, bram_wrdata_a, mk(0, 0));

`ifdef FMAP_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 96; c++) step(4'b0011, 1'b0);
    step(4'b0000, 1'b0);
    chk("st_beats", 96, beats, 16'd48);
    chk("st_stall_nz", 96, stall_cycles != 0, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("st_beats_clr", 98, beats, 16'd0);
    chk("st_stall_clr", 98, stall_cycles, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_write_arbiter.md
Name: fmap_write_arbiter

Overview:
- Shares a single BRAM write port (port A) between N_REQ feature-map capture channels, each producing one 8-bit-grayscale column word per beat.
- Round-robin arbitration between channels.
- Generates the BRAM address from per-channel column counters, drives the multi-cycle write-enable pulse, and reports per-channel and whole-layer frame completion.
- Sits between the per-channel fp16-to-gray capture stages and the display/readback BRAM.

Parameters:
- N_REQ, 4, number of requesting channels.
- DATA_W, 192, write word width (24 pixels x 8 bits).
- ADDR_W, 12, BRAM address width.
- COLS, 24, columns per channel frame.
- BASE_ADDR, 12'h000, address of channel 0, column 0.
- CH_STRIDE, 12'h020, address offset between channels; must be >= COLS.
- HOLD_CYC, 2, cycles bram_we_a is held high per beat; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse: begin new layer; clears counters and done mask.
- req_valid  in  N_REQ  channel i has a column word ready.
- req_data  in  N_REQ x DATA_W  column word per channel.
- req_ready  out  N_REQ  one-cycle accept pulse; at most one bit set.
- bram_addr_a  out  ADDR_W  BRAM address.
- bram_wrdata_a  out  DATA_W  BRAM write data.
- bram_we_a  out  1  BRAM write enable.
- ch_done  out  N_REQ  one-cycle pulse when channel i writes its last column.
- all_done  out  1  one-cycle pulse when every channel has completed since the last frame_start.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; bram_addr_a = BASE_ADDR; col_cnt[*] = 0; done_mask = 0; rr_ptr = 0; state IDLE.
- Reset mid-write aborts immediately: bram_we_a drops with the reset assertion.

State machine:
- IDLE: if any eligible request exists, grant it → WRITE with hold_cnt = HOLD_CYC-1. Otherwise stay in IDLE.
- WRITE: bram_we_a = 1; addr and data held. Decrement hold_cnt.
  - When hold_cnt reaches 0, this is the final write cycle. Arbitrate again in this cycle.
  - Grant → remain in WRITE with the new beat loaded for the next cycle (back-to-back).
  - No grant → IDLE.
- Throughput: one beat per HOLD_CYC cycles under continuous requests.

Arbitration and accept:
- Eligible = req_valid & ~done_mask.
- Winner is the first eligible index at or after rr_ptr, wrapping modulo N_REQ. After a grant, rr_ptr = winner+1 mod N_REQ.
- Grant in cycle T:
  - req_ready[winner] = 1 in cycle T.
  - In cycle T+1 through T+HOLD_CYC: bram_wrdata_a = req_data[winner] sampled at T; bram_addr_a = BASE_ADDR + winner*CH_STRIDE + col_cnt[winner]; bram_we_a = 1.
- Address arithmetic is modulo 2^ADDR_W.
- Requester must hold req_valid and req_data until it sees req_ready. Data is captured on the accept edge.

Column counters and completion:
- On grant, col_cnt[winner] increments.
- If col_cnt[winner] == COLS-1, it wraps to 0, done_mask[winner] sets, and ch_done[winner] pulses in cycle T+1.
- all_done pulses one cycle after the cycle in which done_mask becomes all-ones. It pulses only once per frame.

frame_start:
- Clears col_cnt, done_mask and rr_ptr to 0.
- Suppresses any grant in the same cycle: req_ready = 0 that cycle.
- A write already in progress completes its remaining hold cycles unchanged.

overrun:
- Sets when req_valid[i] && done_mask[i] && !frame_start.
- Cleared only by reset.

Optional Feature:
- Macro: FMAP_ARB_STATS_EN.
- Defined:
  - Adds output stall_cycles (32 bits) and output beats (16 bits).
  - stall_cycles counts cycles where any eligible request is not granted; saturates at all-ones.
  - beats counts accepted beats.
  - Both counters clear on reset and on frame_start.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Single channel, N_REQ=4, HOLD_CYC=2, req_valid[1] held high → req_ready[1] every 2 cycles. Writes go to addresses 0x020..0x037, bram_we_a high continuously. ch_done[1] pulses after the 24th beat; req_ready[1] then stays low; overrun sets while req_valid[1] remains high.
- All four channels continuously valid → grant order 0,1,2,3,0,1,… After 96 beats, all_done pulses exactly once, one cycle after the last ch_done. Last write goes to address 0x077.
- Channels 0 and 2 valid, rr_ptr=1 → channel 2 granted first, then 0, then 2. No channel is ever granted twice while the other waits.
- frame_start asserted during the second hold cycle of a channel-3 beat → that write completes at its original address; no req_ready in the frame_start cycle; next channel-3 beat goes to address 0x060.
- rst_n driven low during a write → bram_we_a drops to 0 asynchronously. After release: bram_addr_a = 0x000, counters zero, first beat from channel 0 writes address 0x000.
- With FMAP_ARB_STATS_EN: two channels continuously valid, HOLD_CYC=2, 48 beats → beats = 48 and stall_cycles > 0. Both counters read 0 after frame_start.
